// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, read-return owner codes
// and the helper that decides who owns the read data returning next cycle.
package dmem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W       = 10;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FORCE     = 2'd1,
    ST_HALT_PEND = 2'd2,
    ST_HALTED    = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  // Writes return nothing, so only a granted read claims the return slot.
  function automatic owner_t read_owner(input logic cpu_gnt, input logic dbg_gnt, input logic we);
    if (we)      return OWN_NONE;
    if (cpu_gnt) return OWN_CPU;
    if (dbg_gnt) return OWN_DBG;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Counts consecutive cycles the debug port lost to the CPU; flags when the next
// forced debug slot must be taken. Saturates at STARVE_LIMIT-1.
module dmem_port_arbiter_starve_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam int unsigned CNT_W   = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam int unsigned CNT_MAX = STARVE_LIMIT - 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (32'(cnt) < CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // This denial brings the count to STARVE_LIMIT-1: the following cycle belongs to debug.
  assign limit_hit = inc && ((32'(cnt) + 32'd2) >= STARVE_LIMIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port synchronous data memory between the CPU MEM stage and the
// debug/loader port, with starvation-forced debug slots and a CPU halt handshake.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_halt_req,
  output logic              dbg_halt_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, state_nxt;
  owner_t     rd_owner;
  logic       cpu_gnt;
  logic       starve_inc, starve_clr, starve_hit;

  assign starve_inc = reset && (state == ST_RUN) && cpu_req && dbg_req;
  assign starve_clr = dbg_gnt || (state == ST_FORCE);

  dmem_port_arbiter_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .limit_hit(starve_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant selection and next state; nothing is granted while reset is held.
  always_comb begin
    state_nxt = state;
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    cpu_stall = 1'b0;
    if (reset) begin
      unique case (state)
        ST_RUN: begin
          if (cpu_req) begin
            cpu_gnt = 1'b1;
          end else begin
            dbg_gnt = dbg_req;
          end
          if (dbg_halt_req) begin
            state_nxt = ST_HALT_PEND;
          end else if (starve_hit) begin
            state_nxt = ST_FORCE;
          end
        end
        ST_FORCE: begin
          dbg_gnt   = dbg_req;
          cpu_stall = cpu_req;
          state_nxt = dbg_halt_req ? ST_HALT_PEND : ST_RUN;
        end
        ST_HALT_PEND: begin
          // Any CPU read granted last cycle returns during this cycle, so one cycle here suffices.
          cpu_stall = 1'b1;
          dbg_gnt   = dbg_req;
          state_nxt = dbg_halt_req ? ST_HALTED : ST_RUN;
        end
        ST_HALTED: begin
          cpu_stall = 1'b1;
          dbg_gnt   = dbg_req;
          if (!dbg_halt_req) begin
            state_nxt = ST_RUN;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // Memory strobe follows whichever requester holds the grant.
  always_comb begin
    mem_en    = cpu_gnt || dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= read_owner(cpu_gnt, dbg_gnt, mem_we);
    end
  end

  assign cpu_rdata    = (rd_owner == OWN_CPU) ? mem_rdata : '0;
  assign dbg_rdata    = (rd_owner == OWN_DBG) ? mem_rdata : '0;
  assign dbg_rvalid   = (rd_owner == OWN_DBG);
  assign dbg_halt_ack = (state == ST_HALTED);

endmodule
